// File: rtl/hex_dump_tx.sv
// Serialises a captured word into ASCII hex characters, one strobe at a time,
// for a uart_tx-style simplex transmitter, with an optional CR/LF terminator.
module hex_dump_tx #(
  parameter int DATA_W    = 256,
  parameter int UPPERCASE = 1,
  parameter int BYTE_REV  = 0,
  parameter int NEWLINE   = 1,
  parameter int BUSY_LAT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic [2:0]        state_dbg
);

  localparam int NIBS = DATA_W / 4;
  localparam int N    = NIBS + 2 * NEWLINE;
  localparam int CW   = $clog2(N + 1);
  localparam int HW   = (BUSY_LAT < 1) ? 1 : $clog2(BUSY_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT_TX = 3'd2,
    S_STROBE  = 3'd3,
    S_HOLD    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] data_q;
  logic [CW-1:0]     cnt;
  logic [HW-1:0]     hold;
  logic [7:0]        tx_data_q;
  logic [CW-1:0]     nib_pos;
  logic [3:0]        nib;
  logic [7:0]        char_nx;

  // Handshake: tx_valid is a single-cycle strobe with tx_data; it is only
  // raised when tx_busy is low and the post-strobe holdoff has expired, since
  // the transmitter raises tx_busy a few cycles after accepting a character.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hold      <= '0;
      tx_data_q <= 8'h00;
      data_q    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            data_q <= data;
            cnt    <= '0;
          end
        end
        S_LOAD: cnt <= '0;
        S_WAIT_TX: begin
          if (state_nx == S_STROBE) tx_data_q <= char_nx;
        end
        S_STROBE: begin
          hold <= HW'(BUSY_LAT);
          if (cnt != CW'(N)) cnt <= cnt + 1'b1;
        end
        S_HOLD: begin
          if (hold != '0) hold <= hold - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = S_LOAD;
      S_LOAD:    state_nx = S_WAIT_TX;
      S_WAIT_TX: if (!tx_busy && hold == '0) state_nx = S_STROBE;
      S_STROBE:  state_nx = S_HOLD;
      S_HOLD: begin
        if (hold <= HW'(1)) state_nx = (cnt == CW'(N)) ? S_DONE : S_WAIT_TX;
      end
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    tx_valid  = (state == S_STROBE);
    tx_data   = tx_data_q;
    state_dbg = state;
  end

  // Nibble position counted from bit 0; even characters take the high nibble.
  always_comb begin
    if (BYTE_REV != 0) nib_pos = {cnt[CW-1:1], ~cnt[0]};
    else               nib_pos = CW'(NIBS - 1) - cnt;
    nib = 4'h0;
    for (int i = 0; i < NIBS; i++) begin
      if (nib_pos == CW'(i)) nib = data_q[4*i +: 4];
    end
    if (cnt >= CW'(NIBS))   char_nx = (cnt == CW'(NIBS)) ? 8'h0D : 8'h0A;
    else if (nib < 4'd10)   char_nx = 8'h30 + {4'h0, nib};
    else if (UPPERCASE != 0) char_nx = 8'h37 + {4'h0, nib};
    else                    char_nx = 8'h57 + {4'h0, nib};
  end

endmodule

// File: tb/tb_hex_dump_tx.sv
// Directed bench for hex_dump_tx: three parameterisations, strobe timing,
// busy-gated transmitter model, mid-dump start, reset abandon, 256-bit digest.
module tb_hex_dump_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   base = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 0: DATA_W=16, defaults
  logic        start0 = 1'b0;
  logic [15:0] data0 = '0;
  logic        busy0, done0, txv0;
  logic [7:0]  txd0;
  logic [2:0]  st0;
  logic        model_en = 1'b0;
  int          bcnt = 0;
  logic        txb0;
  assign txb0 = model_en && (bcnt != 0);

  // instance 1: LSB-first bytes, lowercase, no terminator
  logic        start1 = 1'b0;
  logic [15:0] data1 = '0;
  logic        busy1, done1, txv1;
  logic [7:0]  txd1;
  logic [2:0]  st1;
  logic        txb1 = 1'b0;

  // instance 2: 256-bit defaults
  logic         start2 = 1'b0;
  logic [255:0] data2 = '0;
  logic         busy2, done2, txv2;
  logic [7:0]   txd2;
  logic [2:0]   st2;
  logic         txb2 = 1'b0;

  hex_dump_tx #(.DATA_W(16)) u0 (
    .clk(clk), .reset(reset), .start(start0), .data(data0), .busy(busy0),
    .done(done0), .tx_data(txd0), .tx_valid(txv0), .tx_busy(txb0), .state_dbg(st0));

  hex_dump_tx #(.DATA_W(16), .UPPERCASE(0), .BYTE_REV(1), .NEWLINE(0)) u1 (
    .clk(clk), .reset(reset), .start(start1), .data(data1), .busy(busy1),
    .done(done1), .tx_data(txd1), .tx_valid(txv1), .tx_busy(txb1), .state_dbg(st1));

  hex_dump_tx #(.DATA_W(256)) u2 (
    .clk(clk), .reset(reset), .start(start2), .data(data2), .busy(busy2),
    .done(done2), .tx_data(txd2), .tx_valid(txv2), .tx_busy(txb2), .state_dbg(st2));

  // Transmitter model: tx_busy high for 10 cycles, starting one cycle after a strobe.
  always @(posedge clk) begin
    if (model_en && txv0) bcnt <= 10;
    else if (bcnt != 0)   bcnt <= bcnt - 1;
  end

  logic [7:0] exp_q[$];
  logic [7:0] got_c[$];
  int         got_t[$];
  int         got_d[$];
  logic       prev0 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Only one instance is active at a time, so all share one capture queue.
  always @(negedge clk) begin
    if (txv0) begin
      got_c.push_back(txd0);
      got_t.push_back(cyc - base);
      check("no_b2b0", {31'd0, prev0}, 32'd0);
      check("strobe_while_busy0", {31'd0, txb0}, 32'd0);
    end
    if (txv1) begin
      got_c.push_back(txd1);
      got_t.push_back(cyc - base);
    end
    if (txv2) begin
      got_c.push_back(txd2);
      got_t.push_back(cyc - base);
    end
    if (done0 || done1 || done2) got_d.push_back(cyc - base);
    prev0 <= txv0;
  end

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (got_d.size() == 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(got_d.size() > 0), 32'd1);
  endtask

  task automatic score(input string tag, input int first, input int gap, input int done_at);
    check({tag, "_count"}, 32'(got_c.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_c.size()) begin
        check($sformatf("%s_chr%0d", tag, i), {24'd0, got_c[i]}, {24'd0, exp_q[i]});
        check($sformatf("%s_cyc%0d", tag, i), 32'(got_t[i]), 32'(first + i * gap));
      end
    end
    check({tag, "_done_count"}, 32'(got_d.size()), 32'd1);
    if (got_d.size() > 0) check({tag, "_done_cyc"}, 32'(got_d[0]), 32'(done_at));
    exp_q.delete();
    got_c.delete();
    got_t.delete();
    got_d.delete();
  endtask

  task automatic exp_a53c();
    exp_q.push_back(8'h41); exp_q.push_back(8'h35); exp_q.push_back(8'h33);
    exp_q.push_back(8'h43); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  task automatic go0(input logic [15:0] d);
    @(posedge clk); #1;
    data0 = d; start0 = 1'b1; base = cyc;
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  initial begin
    string digest;
    logic [7:0] ch;
    int n;
    digest = "3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532";

    // reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy0", {31'd0, busy0}, 32'd0);
    check("rst_done0", {31'd0, done0}, 32'd0);
    check("rst_valid0", {31'd0, txv0}, 32'd0);
    check("rst_data0", {24'd0, txd0}, 32'd0);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    check("rst_valid2", {31'd0, txv2}, 32'd0);
    check("rst_data2", {24'd0, txd2}, 32'd0);

    // basic dump of 16'hA53C, then back-to-back start in the cycle after done
    go0(16'hA53C);
    @(negedge clk);
    check("basic_busy_load", {31'd0, busy0}, 32'd1);
    exp_a53c();
    wait_done("basic", 200);
    score("basic", 3, 4, 26);
    @(posedge clk); #1;
    data0 = 16'h0009; start0 = 1'b1; base = cyc;
    @(negedge clk);
    check("busy_drop_after_done", {31'd0, busy0}, 32'd0);
    @(posedge clk); #1;
    start0 = 1'b0;
    exp_q.push_back(8'h30); exp_q.push_back(8'h30); exp_q.push_back(8'h30);
    exp_q.push_back(8'h39); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    wait_done("b2b", 200);
    score("b2b", 3, 4, 26);

    // mid-dump start with different data is ignored, no restart after done
    go0(16'hA53C);
    repeat (4) @(posedge clk);
    #1 data0 = 16'hFFFF; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    exp_a53c();
    wait_done("restart", 200);
    score("restart", 3, 4, 26);
    repeat (20) @(negedge clk);
    check("no_restart_chars", 32'(got_c.size()), 32'd0);
    check("no_restart_busy", {31'd0, busy0}, 32'd0);

    // busy-gated transmitter
    model_en = 1'b1;
    go0(16'hA53C);
    exp_a53c();
    wait_done("txbusy", 400);
    score("txbusy", 3, 12, 66);
    repeat (12) @(posedge clk);
    #1 model_en = 1'b0;

    // reset after the 3rd character abandons the dump
    go0(16'hA53C);
    n = 0;
    while (got_c.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reach3", 32'(got_c.size()), 32'd3);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy0}, 32'd0);
    check("rst_mid_done", {31'd0, done0}, 32'd0);
    check("rst_mid_valid", {31'd0, txv0}, 32'd0);
    check("rst_mid_data", {24'd0, txd0}, 32'd0);
    check("rst_mid_state", {29'd0, st0}, 32'd0);
    repeat (10) @(negedge clk);
    check("rst_mid_nochars", 32'(got_c.size()), 32'd3);
    check("rst_mid_nodone", 32'(got_d.size()), 32'd0);
    got_c.delete(); got_t.delete(); got_d.delete();
    go0(16'hA53C);
    exp_a53c();
    wait_done("after_rst", 200);
    score("after_rst", 3, 4, 26);

    // LSB-first, lowercase, no terminator
    @(posedge clk); #1;
    data1 = 16'h12EF; start1 = 1'b1; base = cyc;
    @(posedge clk); #1 start1 = 1'b0;
    exp_q.push_back(8'h65); exp_q.push_back(8'h66);
    exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    wait_done("rev", 200);
    score("rev", 3, 4, 18);

    // SHA3-256("abc") digest
    @(posedge clk); #1;
    data2 = 256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532;
    start2 = 1'b1; base = cyc;
    @(posedge clk); #1 start2 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ch = digest[i];
      if (ch >= 8'h61) ch = ch - 8'h20;
      exp_q.push_back(ch);
    end
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    wait_done("sha3", 1000);
    score("sha3", 3, 4, 266);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
